// File: rtl/rat_pkg.sv
// -----------------------------------------------------------------------------
// rat_pkg
// Shared definitions for the RAT CPU front end: the program address width,
// the interrupt vector and the encoding of the program-counter source select.
// -----------------------------------------------------------------------------
package rat_pkg;

    localparam int              ADDR_W    = 10;
    localparam logic [ADDR_W-1:0] INTR_VEC = 10'h3FF;
    localparam int              RAS_DEPTH = 8;

    // Next-PC source when PC_LD is asserted. The reserved code falls back to
    // the immediate target so a stray select still produces a defined PC.
    typedef enum logic [1:0] {
        PC_SEL_IMM  = 2'd0,
        PC_SEL_RET  = 2'd1,
        PC_SEL_INTR = 2'd2,
        PC_SEL_RSVD = 2'd3
    } pc_sel_t;

endpackage : rat_pkg

// File: rtl/ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack
// Small hardware LIFO holding return addresses.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (empties the stack)
//   push, pop  : operation requests; both at once is a conflict and is ignored
//   din        : value written on a push
//   top        : most recently pushed entry (meaningless while empty)
//   full/empty : occupancy flags
//   err        : one-cycle pulse on overflow, underflow or push/pop conflict
// -----------------------------------------------------------------------------
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty,
    output logic         err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !pop && !full;
    assign do_pop  = pop && !push && !empty;
    assign err     = (push && pop) || (push && full) || (pop && empty);

    // The count is the next free slot; the top lives one below it.
    assign wr_ptr  = PTR_W'(cnt_q);
    assign top_ptr = PTR_W'(cnt_q - CNT_W'(1));
    assign top     = mem[top_ptr];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (do_push) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (do_pop) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; the count alone defines which
    // entries are valid, so clearing the array would buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule : ret_stack

// File: rtl/prog_counter.sv
// -----------------------------------------------------------------------------
// prog_counter
// Program-counter stage of the RAT CPU. PROG_ADDR comes straight from the PC
// register and feeds the program ROM, whose registered PROG_IR follows one
// clock later. The next PC is the selected load source, PC+1, or the current
// PC, in that priority.
//
// Build option
//   PC_RAS_EN : when defined, an internal return-address stack supplies the
//               return target and RAS_ERR flags stack misuse. When undefined,
//               the return target is FROM_STACK, PC_PUSH/PC_POP are ignored
//               and RAS_ERR is 0.
//
// Ports
//   CLK, RST_N   : clock, asynchronous active-low reset
//   PC_LD        : load the PC from the PC_MUX_SEL source (wins over PC_INC)
//   PC_INC       : advance the PC by one
//   PC_MUX_SEL   : 0 immediate, 1 return target, 2 interrupt vector, 3 as 0
//   FROM_IMM     : branch/call target
//   FROM_STACK   : return target from scratch RAM
//   PC_PUSH      : call/interrupt, push PC_NEXT on the internal stack
//   PC_POP       : return, pop the internal stack (with PC_LD and select 1)
//   PROG_ADDR    : current PC, registered
//   PC_NEXT      : PC+1, combinational, wraps
//   IR_VALID     : PROG_IR belongs to the previous PROG_ADDR
//   RAS_ERR      : sticky stack overflow/underflow/conflict flag
// -----------------------------------------------------------------------------
module prog_counter
    import rat_pkg::*;
#(
    parameter int                ADDR_W    = rat_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] INTR_VEC  = rat_pkg::INTR_VEC,
    parameter int                RAS_DEPTH = rat_pkg::RAS_DEPTH
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PC_LD,
    input  logic              PC_INC,
    input  logic [1:0]        PC_MUX_SEL,
    input  logic [ADDR_W-1:0] FROM_IMM,
    input  logic [ADDR_W-1:0] FROM_STACK,
    input  logic              PC_PUSH,
    input  logic              PC_POP,
    output logic [ADDR_W-1:0] PROG_ADDR,
    output logic [ADDR_W-1:0] PC_NEXT,
    output logic              IR_VALID,
    output logic              RAS_ERR
);

    pc_sel_t           sel;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] ret_target;
    logic              ir_valid_q;

    assign sel       = pc_sel_t'(PC_MUX_SEL);
    assign PC_NEXT   = pc_q + ADDR_W'(1);
    assign PROG_ADDR = pc_q;
    assign IR_VALID  = ir_valid_q;

`ifdef PC_RAS_EN
    logic              ld_ret;
    logic              conflict;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_empty;
    logic              stk_err;
    logic              unused_stk_full;
    logic [ADDR_W-1:0] stk_top;
    logic              ras_err_q;

    assign ld_ret   = PC_LD && (sel == PC_SEL_RET);
    // A simultaneous push and pop leaves the stack alone, whatever the PC does.
    assign conflict = PC_PUSH && PC_POP;
    assign stk_push = PC_PUSH && !PC_POP;
    assign stk_pop  = PC_POP && ld_ret && !PC_PUSH;

    ret_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (PC_NEXT),
        .top   (stk_top),
        .full  (unused_stk_full),
        .empty (stk_empty),
        .err   (stk_err)
    );

    // An empty stack falls back to the software-managed return address.
    assign ret_target = stk_empty ? FROM_STACK : stk_top;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ras_err_q <= 1'b0;
        end else if (conflict || stk_err) begin
            ras_err_q <= 1'b1;
        end
    end

    assign RAS_ERR = ras_err_q;
`else
    logic unused_ras;

    assign unused_ras = PC_PUSH ^ PC_POP ^ (RAS_DEPTH > 0);
    assign ret_target = FROM_STACK;
    assign RAS_ERR    = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // leaves pc_d unassigned and no latch is inferred.
    always_comb begin
        pc_d = pc_q;
        if (PC_LD) begin
            case (sel)
                PC_SEL_RET:  pc_d = ret_target;
                PC_SEL_INTR: pc_d = INTR_VEC;
                default:     pc_d = FROM_IMM;
            endcase
        end else if (PC_INC) begin
            pc_d = PC_NEXT;
        end
    end

    // IR_VALID drops for the cycle after a redirect: the ROM word then on
    // PROG_IR was fetched from the address before the load.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_valid_q <= !PC_LD;
        end
    end

endmodule : prog_counter

// File: tb/tb_prog_counter.sv
// -----------------------------------------------------------------------------
// tb_prog_counter
// Self-checking bench for prog_counter. Each scenario drives rows of stimulus;
// the expected PROG_ADDR / IR_VALID / RAS_ERR for a row is queued when it is
// driven and compared after the clock edge that applies it. Build with
// +define+PC_RAS_EN to exercise the internal return stack.
// -----------------------------------------------------------------------------
module tb_prog_counter;
    import rat_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pc_ld = 1'b0;
    logic          pc_inc = 1'b0;
    logic [1:0]    pc_mux_sel = 2'd0;
    logic [AW-1:0] from_imm = '0;
    logic [AW-1:0] from_stack = '0;
    logic          pc_push = 1'b0;
    logic          pc_pop = 1'b0;
    logic [AW-1:0] prog_addr;
    logic [AW-1:0] pc_next;
    logic          ir_valid;
    logic          ras_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          ld;
        logic          inc;
        logic [1:0]    sel;
        logic [AW-1:0] imm;
        logic [AW-1:0] stk;
        logic          push;
        logic          pop;
        logic [AW-1:0] addr;
        logic          err;
    } row_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          valid;
        logic          err;
    } exp_t;

    exp_t sb[$];

    prog_counter dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .PC_LD      (pc_ld),
        .PC_INC     (pc_inc),
        .PC_MUX_SEL (pc_mux_sel),
        .FROM_IMM   (from_imm),
        .FROM_STACK (from_stack),
        .PC_PUSH    (pc_push),
        .PC_POP     (pc_pop),
        .PROG_ADDR  (prog_addr),
        .PC_NEXT    (pc_next),
        .IR_VALID   (ir_valid),
        .RAS_ERR    (ras_err)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic ld, input logic inc, input logic [1:0] sel,
                                input logic [AW-1:0] imm, input logic [AW-1:0] stk,
                                input logic push, input logic pop,
                                input logic [AW-1:0] addr, input logic err);
        row_t r;
        r.ld = ld; r.inc = inc; r.sel = sel; r.imm = imm; r.stk = stk;
        r.push = push; r.pop = pop; r.addr = addr; r.err = err;
        return r;
    endfunction

    // Drive one row, queue what the PC must look like after the edge, then
    // step to just past that edge. A load always invalidates the next IR.
    task automatic apply(input row_t r);
        exp_t e;
        pc_ld = r.ld; pc_inc = r.inc; pc_mux_sel = r.sel;
        from_imm = r.imm; from_stack = r.stk; pc_push = r.push; pc_pop = r.pop;
        e.addr = r.addr; e.valid = !r.ld; e.err = r.err;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_ld = 1'b0; pc_inc = 1'b0; pc_mux_sel = 2'd0;
        from_imm = '0; from_stack = '0; pc_push = 1'b0; pc_pop = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (prog_addr !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", prog_addr); end
        checks++;
        if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
        checks++;
        if (ras_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ras_err); end
        checks++;
        if (pc_next !== 10'h001) begin errors++; $display("FAIL reset_next: got %h want 001", pc_next); end
        @(negedge clk);
        rst_n = 1'b1;
        pc_inc = 1'b1;
        #1;
        checks++;
        if ({prog_addr, ir_valid} !== {10'h000, 1'b0}) begin
            errors++; $display("FAIL release_first_cycle: got %h/%b want 000/0", prog_addr, ir_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            apply(mk(1'b0, 1'b1, PC_SEL_IMM, '0, '0, 1'b0, 1'b0, AW'(i), 1'b0));
            e = sb.pop_front();
            checks++;
            if ({prog_addr, ir_valid, ras_err} !== {e.addr, e.valid, e.err}) begin
                errors++;
                $display("FAIL reset_inc step %0d: got %h/%b/%b want %h/%b/%b",
                         i, prog_addr, ir_valid, ras_err, e.addr, e.valid, e.err);
            end
        end
    endtask

    task automatic test_wrap();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1'b1, 1'b0, PC_SEL_IMM, 10'h3FF, '0, 1'b0, 1'b0, 10'h3FF, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, PC_SEL_IMM, '0,      '0, 1'b0, 1'b0, 10'h000, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, PC_SEL_IMM, '0,      '0, 1'b0, 1'b0, 10'h000, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({prog_addr, ir_valid, ras_err} !== {e.addr, e.valid, e.err}) begin
                errors++;
                $display("FAIL wrap row %0d: got %h/%b/%b want %h/%b/%b",
                         i, prog_addr, ir_valid, ras_err, e.addr, e.valid, e.err);
            end
            if (i == 0) begin
                checks++;
                if (pc_next !== 10'h000) begin errors++; $display("FAIL wrap_next: got %h want 000", pc_next); end
            end
        end
    endtask

    task automatic test_call_ret();
        row_t rows[$];
        exp_t e;
`ifdef PC_RAS_EN
        logic [AW-1:0] ret_src = 10'h2AA;   // stack must win over scratch RAM
`else
        logic [AW-1:0] ret_src = 10'h006;   // scratch RAM holds the return
`endif
        rows.push_back(mk(1'b1, 1'b0, PC_SEL_IMM, 10'h005, '0,      1'b0, 1'b0, 10'h005, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, PC_SEL_IMM, 10'h120, '0,      1'b1, 1'b0, 10'h120, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, PC_SEL_IMM, '0,      '0,      1'b0, 1'b0, 10'h121, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, PC_SEL_RET, '0,      ret_src, 1'b0, 1'b1, 10'h006, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, PC_SEL_IMM, '0,      '0,      1'b0, 1'b0, 10'h007, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({prog_addr, ir_valid, ras_err} !== {e.addr, e.valid, e.err}) begin
                errors++;
                $display("FAIL call_ret row %0d: got %h/%b/%b want %h/%b/%b",
                         i, prog_addr, ir_valid, ras_err, e.addr, e.valid, e.err);
            end
        end
    endtask

    task automatic test_load_priority();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1'b1, 1'b0, PC_SEL_IMM,  10'h042, '0, 1'b0, 1'b0, 10'h042, 1'b0));
        rows.push_back(mk(1'b1, 1'b1, PC_SEL_INTR, 10'h000, '0, 1'b0, 1'b0, 10'h3FF, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, PC_SEL_RSVD, 10'h155, '0, 1'b0, 1'b0, 10'h155, 1'b0));
        rows.push_back(mk(1'b0, 1'b1, PC_SEL_IMM,  10'h000, '0, 1'b0, 1'b0, 10'h156, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({prog_addr, ir_valid, ras_err} !== {e.addr, e.valid, e.err}) begin
                errors++;
                $display("FAIL load_priority row %0d: got %h/%b/%b want %h/%b/%b",
                         i, prog_addr, ir_valid, ras_err, e.addr, e.valid, e.err);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        rst_n = 1'b0;   // mid-cycle, away from any edge
        #2;
        checks++;
        if ({prog_addr, ir_valid, ras_err} !== {10'h000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_reset: got %h/%b/%b want 000/0/0", prog_addr, ir_valid, ras_err);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1'b0, 1'b1, PC_SEL_IMM, '0, '0, 1'b0, 1'b0, 10'h001, 1'b0));
        e = sb.pop_front();
        checks++;
        if ({prog_addr, ir_valid, ras_err} !== {e.addr, e.valid, e.err}) begin
            errors++;
            $display("FAIL async_release: got %h/%b/%b want %h/%b/%b",
                     prog_addr, ir_valid, ras_err, e.addr, e.valid, e.err);
        end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras_underflow();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1'b1, 1'b0, PC_SEL_RET, '0, 10'h0AB, 1'b0, 1'b1, 10'h0AB, 1'b1));
        rows.push_back(mk(1'b0, 1'b1, PC_SEL_IMM, '0, '0,      1'b0, 1'b0, 10'h0AC, 1'b1));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({prog_addr, ir_valid, ras_err} !== {e.addr, e.valid, e.err}) begin
                errors++;
                $display("FAIL ras_underflow row %0d: got %h/%b/%b want %h/%b/%b",
                         i, prog_addr, ir_valid, ras_err, e.addr, e.valid, e.err);
            end
        end
    endtask

    task automatic test_ras_conflict();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(1'b0, 1'b0, PC_SEL_IMM, '0,      '0,      1'b0, 1'b0, 10'h000, 1'b0));
        rows.push_back(mk(1'b1, 1'b0, PC_SEL_IMM, 10'h077, '0,      1'b1, 1'b1, 10'h077, 1'b1));
        rows.push_back(mk(1'b1, 1'b0, PC_SEL_RET, '0,      10'h0AB, 1'b0, 1'b1, 10'h0AB, 1'b1));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({prog_addr, ir_valid, ras_err} !== {e.addr, e.valid, e.err}) begin
                errors++;
                $display("FAIL ras_conflict row %0d: got %h/%b/%b want %h/%b/%b",
                         i, prog_addr, ir_valid, ras_err, e.addr, e.valid, e.err);
            end
        end
    endtask

    task automatic test_ras_overflow();
        logic [AW-1:0] model[$];
        logic [AW-1:0] cur;
        logic [AW-1:0] imm;
        logic [AW-1:0] ret;
        exp_t          e;
        do_reset();
        cur = '0;
        for (int i = 0; i < 9; i++) begin
            imm = 10'h100 + AW'(i * 8);
            if (model.size() < RAS_DEPTH) model.push_back(cur + AW'(1));
            apply(mk(1'b1, 1'b0, PC_SEL_IMM, imm, '0, 1'b1, 1'b0, imm, (i == 8)));
            cur = imm;
            e = sb.pop_front();
            checks++;
            if ({prog_addr, ir_valid, ras_err} !== {e.addr, e.valid, e.err}) begin
                errors++;
                $display("FAIL ras_push %0d: got %h/%b/%b want %h/%b/%b",
                         i, prog_addr, ir_valid, ras_err, e.addr, e.valid, e.err);
            end
        end
        for (int i = 0; i < 9; i++) begin
            ret = (model.size() > 0) ? model.pop_back() : 10'h2AA;
            apply(mk(1'b1, 1'b0, PC_SEL_RET, '0, 10'h2AA, 1'b0, 1'b1, ret, 1'b1));
            e = sb.pop_front();
            checks++;
            if ({prog_addr, ir_valid, ras_err} !== {e.addr, e.valid, e.err}) begin
                errors++;
                $display("FAIL ras_pop %0d: got %h/%b/%b want %h/%b/%b",
                         i, prog_addr, ir_valid, ras_err, e.addr, e.valid, e.err);
            end
        end
    endtask
`else
    task automatic test_no_ras();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1'b1, 1'b0, PC_SEL_RET, '0, 10'h0AB, 1'b1, 1'b1, 10'h0AB, 1'b0));
        rows.push_back(mk(1'b0, 1'b0, PC_SEL_IMM, '0, '0,      1'b1, 1'b0, 10'h0AB, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({prog_addr, ir_valid, ras_err} !== {e.addr, e.valid, e.err}) begin
                errors++;
                $display("FAIL no_ras row %0d: got %h/%b/%b want %h/%b/%b",
                         i, prog_addr, ir_valid, ras_err, e.addr, e.valid, e.err);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wrap();
        test_call_ret();
        test_load_priority();
        test_async_reset();
`ifdef PC_RAS_EN
        test_ras_underflow();
        test_ras_conflict();
        test_ras_overflow();
`else
        test_no_ras();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_prog_counter

// File: doc/prog_counter.md
# prog_counter

Program-counter stage of the RAT CPU. It holds the 10-bit instruction address and drives `PROG_ADDR` of the program ROM directly from a register, which returns `PROG_IR` one clock later. It computes the next PC from one of these sources, under control-unit direction:
- increment;
- branch/call immediate;
- return target;
- interrupt vector.

It optionally keeps an internal hardware return-address stack.

## Interface
- `ADDR_W`, 10, PC/ROM address width.
- `INTR_VEC`, 10'h3FF, interrupt vector address.
- `RAS_DEPTH`, 8, return-stack entries (used only with `PC_RAS_EN`).

- `CLK`  in  1  system clock; all state updates on rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `PC_LD`  in  1  load next PC from the `PC_MUX_SEL` source.
- `PC_INC`  in  1  increment PC (ignored when `PC_LD`=1).
- `PC_MUX_SEL`  in  2  source select: 0 = `FROM_IMM`, 1 = return target, 2 = `INTR_VEC`, 3 = reserved (treated as 0).
- `FROM_IMM`  in  ADDR_W  branch/call target from the IR.
- `FROM_STACK`  in  ADDR_W  return target from scratch RAM (used when `PC_RAS_EN` is undefined).
- `PC_PUSH`  in  1  call/interrupt: push return address PC+1.
- `PC_POP`  in  1  return: pop the internal stack.
- `PROG_ADDR`  out  ADDR_W  current PC, registered; feeds the ROM.
- `PC_NEXT`  out  ADDR_W  PC+1, combinational, wraps modulo 2^ADDR_W; the control unit writes it to scratch RAM on call.
- `IR_VALID`  out  1  the ROM's `PROG_IR` corresponds to the previous `PROG_ADDR`.
- `RAS_ERR`  out  1  sticky stack overflow/underflow/conflict flag.

## Operation
- Reset (`RST_N`=0, asynchronous): `PROG_ADDR`=0, `IR_VALID`=0, `RAS_ERR`=0, stack pointer=0 (empty). Stack contents are don't-care.
- Next-PC priority:
  - `PC_LD` selects the `PC_MUX_SEL` source.
  - Else `PC_INC` gives PC+1.
  - Else PC holds.
- Increment wraps 10'h3FF → 10'h000 without a flag.
- `PC_PUSH`=1 pushes `PC_NEXT` (the pre-update PC+1), regardless of `PC_LD`.
- `PC_POP`=1 with `PC_LD`=1 and sel=1 pops. The popped value becomes the new PC.
- `PC_PUSH` and `PC_POP` in the same cycle: stack unchanged, `RAS_ERR` set, PC update proceeds normally.
- Push when full (count = `RAS_DEPTH`): push discarded, `RAS_ERR` set.
- Pop when empty: target = `FROM_STACK`, `RAS_ERR` set.
- `RAS_ERR` clears only on reset.
- `IR_VALID`:
  - 0 in the first cycle after reset release, then 1.
  - Also 0 for the one cycle following any `PC_LD`. This marks the ROM output fetched before the redirect as stale.

## Timing
- `PROG_ADDR` changes only on a rising `CLK` edge, one cycle after `PC_LD`/`PC_INC` is sampled.
- Total fetch latency from a redirect to the target's `PROG_IR`: 2 edges (PC register, then ROM register).
- `PC_NEXT` is combinational from `PROG_ADDR`. There is no input-to-output combinational path other than this one.
- Reset released mid-sequence: the first edge after `RST_N` rises may apply `PC_LD`/`PC_INC` normally.

## Configuration
- `PC_RAS_EN` defined:
  - Internal `RAS_DEPTH`-entry LIFO is instantiated.
  - The return target (sel=1) is the stack top; `FROM_STACK` is used only on underflow.
- `PC_RAS_EN` undefined:
  - No stack storage.
  - `PC_PUSH`/`PC_POP` are ignored.
  - `RAS_ERR` is tied to 0.
  - The return target is always `FROM_STACK`.

## Structure
- Shared package `rat_pkg`:
  - `ADDR_W` constant.
  - `INTR_VEC` constant.
  - `pc_sel_t` enum: `PC_SEL_IMM`, `PC_SEL_RET`, `PC_SEL_INTR`, `PC_SEL_RSVD`.
- Sub-module `ret_stack`: parameterised LIFO with push, pop, top, full, empty and err. It is instantiated only under `PC_RAS_EN`.

## Test plan
- Reset then `PC_INC`=1 for 3 cycles → `PROG_ADDR` 0,1,2,3. `IR_VALID` is 0 then 1.
- PC=10'h3FF, `PC_INC` → `PROG_ADDR`=0.
- PC=5, `PC_LD`=1 with sel=0, `FROM_IMM`=10'h120, `PC_PUSH`=1:
  - → PC=10'h120, 6 pushed, `IR_VALID`=0 for one cycle.
  - Then `PC_LD` with sel=1 and `PC_POP`=1 → PC=6.
- PC=10'h042, `PC_LD` with sel=2, `PC_INC`=1 → PC=10'h3FF (load wins over increment).
- `PC_RAS_EN`: 9 pushes with depth 8 → `RAS_ERR`=1, and 8 pops return the first 8 values in LIFO order.
- `PC_RAS_EN`: pop when empty with `FROM_STACK`=10'h0AB → PC=10'h0AB, `RAS_ERR`=1.
- Without `PC_RAS_EN`: `FROM_STACK`=10'h0AB, sel=1, `PC_LD` → PC=10'h0AB. `RAS_ERR` stays 0.
